multicycle_control_unit: RTL

- Multi-cycle control FSM and instruction register for the 16-bit processor.
- Latches each fetched instruction and drives the register-file read/write address fields.
- Sequences the per-state control strobes (reg_write, reg_dst_write, mem_to_reg, memory and PC enables) consumed by the register file, ALU and memory interface.
- Sits directly upstream of the register file.

---
 rtl/cu_pkg.sv | 60 ++++++
 rtl/instr_class_decode.sv | 34 +++
 rtl/multicycle_control_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM state
// encoding, ALU operation codes, instruction field positions and the
// bundle of registered control strobes.
`timescale 1ns/1ps
package cu_pkg;

  // Instruction field bit positions: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/offset
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_LW  = 4'h4,
    OP_SW  = 4'h5,
    OP_BEQ = 4'h6,
    OP_JMP = 4'h7
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // R-type opcodes map straight onto these through opcode[1:0]
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    ir_load;
    logic    pc_write;
    logic    pc_write_cond;
    alu_op_e alu_op;
    logic    alu_src;
    logic    mem_err;
    logic    illegal_op;
  } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: sorts a 4-bit opcode into the
// instruction classes the control FSM sequences differently.
`timescale 1ns/1ps
module instr_class_decode
  import cu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_rtype,
  output logic       is_lw,
  output logic       is_sw,
  output logic       is_beq,
  output logic       is_jmp,
  output logic       is_illegal
);

  // One-hot class flags; anything outside 0..7 is illegal
  always_comb begin
    is_rtype   = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_jmp     = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: is_rtype = 1'b1;
      OP_LW:   is_lw  = 1'b1;
      OP_SW:   is_sw  = 1'b1;
      OP_BEQ:  is_beq = 1'b1;
      OP_JMP:  is_jmp = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM and instruction register for the 16-bit core.
// Holds the IR, drives register-file address fields straight from it and
// sequences registered Moore control strobes per state.
// Build option: define ILLEGAL_TRAP_EN to trap illegal opcodes in a sticky
// HALT state; otherwise illegal opcodes retire as NOPs.
`timescale 1ns/1ps
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int DW          = 16,
  parameter int AW          = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] instr_in,
  input  logic          mem_ready,
  input  logic          alu_zero,
  output logic [AW-1:0] a_read1,
  output logic [AW-1:0] a_read2,
  output logic [AW-1:0] a_dst,
  output logic          reg_write,
  output logic          reg_dst_write,
  output logic          mem_to_reg,
  output logic          mem_read,
  output logic          mem_write,
  output logic          ir_load,
  output logic          pc_write,
  output logic          pc_write_cond,
  output logic [1:0]    alu_op,
  output logic          alu_src,
  output logic          mem_err,
  output logic          illegal_op
);

  // Last wait-counter value before the handshake is declared lost
  localparam logic [3:0] TMO_LAST = 4'(MEM_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [3:0]    wcnt_q, wcnt_d;
  ctrl_t         ctrl_q, ctrl_d;

  logic is_rtype, is_lw, is_sw, is_beq, is_jmp, is_illegal;
  logic hs_ok;
  logic timeout;
  logic waiting;

  instr_class_decode u_class (
    .opcode     (ir_q[OPC_MSB:OPC_LSB]),
    .is_rtype   (is_rtype),
    .is_lw      (is_lw),
    .is_sw      (is_sw),
    .is_beq     (is_beq),
    .is_jmp     (is_jmp),
    .is_illegal (is_illegal)
  );

  // A handshake only counts while a request is actually on the bus, so the
  // first FETCH after reset (strobes still low) cannot capture stray data.
  // alu_zero is consumed by the PC logic together with pc_write_cond.
  always_comb begin
    hs_ok   = mem_ready & (ctrl_q.mem_read | ctrl_q.mem_write);
    waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !hs_ok;
    timeout = waiting && (wcnt_q == TMO_LAST);
  end

  // State, IR, wait counter and registered strobes; sync active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      wcnt_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Next-state, IR capture and handshake wait counting
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_FETCH: begin
        if (hs_ok) begin
          ir_d    = instr_in;
          state_d = ST_DECODE;
          wcnt_d  = '0;
        end else if (timeout) begin
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      ST_DECODE: begin
        if (is_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_HALT;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_rtype)            state_d = ST_WB;
        else if (is_lw || is_sw) state_d = ST_MEM;
        else                     state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (hs_ok) begin
          state_d = is_lw ? ST_WB : ST_FETCH;
          wcnt_d  = '0;
        end else if (timeout) begin
          state_d = ST_FETCH;
          wcnt_d  = '0;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      ST_WB: state_d = ST_FETCH;
      ST_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        state_d = ST_HALT;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Strobes decoded from the upcoming state so they register in step with it;
  // the fetch capture (ir_load, pc_write) therefore shows in the DECODE cycle
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      ST_FETCH: ctrl_d.mem_read = 1'b1;
      ST_DECODE: begin
        ctrl_d.ir_load  = 1'b1;
        ctrl_d.pc_write = 1'b1;
      end
      ST_EXEC: begin
        if (is_rtype) begin
          ctrl_d.alu_op = alu_op_e'(ir_q[OPC_LSB+1:OPC_LSB]);
        end else if (is_lw || is_sw) begin
          ctrl_d.alu_op  = ALU_ADD;
          ctrl_d.alu_src = 1'b1;
        end else if (is_beq) begin
          ctrl_d.alu_op        = ALU_SUB;
          ctrl_d.pc_write_cond = 1'b1;
        end else if (is_jmp) begin
          ctrl_d.pc_write = 1'b1;
        end
      end
      ST_MEM: begin
        ctrl_d.mem_read  = is_lw;
        ctrl_d.mem_write = is_sw;
      end
      ST_WB: begin
        ctrl_d.reg_write     = 1'b1;
        ctrl_d.reg_dst_write = is_rtype;
        ctrl_d.mem_to_reg    = is_lw;
      end
      ST_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        ctrl_d.illegal_op = 1'b1;
`endif
      end
      default: ctrl_d = '0;
    endcase
    ctrl_d.mem_err = timeout;
  end

  assign a_read1       = ir_q[RS_MSB:RS_LSB];
  assign a_read2       = ir_q[RT_MSB:RT_LSB];
  assign a_dst         = ir_q[RD_MSB:RD_LSB];
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst_write = ctrl_q.reg_dst_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign ir_load       = ctrl_q.ir_load;
  assign pc_write      = ctrl_q.pc_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign alu_op        = ctrl_q.alu_op;
  assign alu_src       = ctrl_q.alu_src;
  assign mem_err       = ctrl_q.mem_err;
  assign illegal_op    = ctrl_q.illegal_op;

  // alu_zero is qualified outside this block by pc_write_cond
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

endmodule
